// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory fetch port.
// Holds the FSM state encoding, the NOP word and the big-endian lane helper.
package imem_pkg;

    localparam logic [31:0] IMEM_NOP = 32'h0000_0000;

    typedef enum logic {
        IMEM_CLEAR = 1'b0,
        IMEM_RUN   = 1'b1
    } imem_state_t;

    // Lane 0 is the lowest byte address, which is the most significant byte.
    function automatic logic [7:0] be_lane(input logic [31:0] word, input logic [1:0] lane);
        logic [7:0] b;
        case (lane)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        return b;
    endfunction

    function automatic logic [31:0] be_pack(input logic [7:0] b0, input logic [7:0] b1,
                                            input logic [7:0] b2, input logic [7:0] b3);
        return {b0, b1, b2, b3};
    endfunction

endpackage

// File: rtl/imem_word_ram.sv
// Single-port word RAM organised as byte lanes, one write and one registered read.
// Contents are never reset; the owner is responsible for clearing it.
module imem_word_ram
    import imem_pkg::*;
#(
    parameter int DEPTH_WORDS = 32,
    parameter int AW          = 5
) (
    input  logic          clk,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata_p1
);

    logic [7:0] mem [DEPTH_WORDS][4];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr][0] <= be_lane(wdata, 2'd0);
            mem[addr][1] <= be_lane(wdata, 2'd1);
            mem[addr][2] <= be_lane(wdata, 2'd2);
            mem[addr][3] <= be_lane(wdata, 2'd3);
        end
        // Read only on accepted fetches so a stalled response stays put.
        if (re) begin
            rdata_p1 <= be_pack(mem[addr][0], mem[addr][1], mem[addr][2], mem[addr][3]);
        end
    end

endmodule

// File: rtl/imem_fetch_port.sv
// Instruction memory with fetch handshake, runtime program load and a post-reset
// hardware clear sequence. Faulting fetches return NOP with instr_fault set.
module imem_fetch_port
    import imem_pkg::*;
#(
    parameter int ADDR_W            = 32,
    parameter int DEPTH_BYTES       = 128,
    parameter int FAULT_ON_MISALIGN = 1
) (
    input  logic              clk,
    input  logic              reset,
    output logic              init_done,
    input  logic              fetch_valid,
    output logic              fetch_ready,
    input  logic [ADDR_W-1:0] fetch_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [31:0]       instr_code,
    output logic              instr_fault,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [31:0]       ld_data,
    output logic              ld_err
);

    localparam int DEPTH_WORDS = DEPTH_BYTES / 4;
    localparam int AW          = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [ADDR_W-1:0] LIMIT     = ADDR_W'(DEPTH_BYTES);
    localparam logic [AW-1:0]     LAST_WORD = AW'(DEPTH_WORDS - 1);

    imem_state_t   state, state_nxt;
    logic [AW-1:0] cnt, cnt_nxt;

    logic          run;
    logic          ld_oob, ld_wr;
    logic          fetch_fault;
    logic          accept;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata;
    logic [31:0]   rdata_p1;
    logic          vld_p1, fault_p1, err_p1;
    logic          unused_ld_lsb;

    assign unused_ld_lsb = ^ld_addr[1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IMEM_CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (state == IMEM_CLEAR) begin
            cnt_nxt = cnt + AW'(1);
            if (cnt == LAST_WORD) begin
                state_nxt = IMEM_RUN;
                cnt_nxt   = '0;
            end
        end
    end

    assign run       = (state == IMEM_RUN);
    assign init_done = run;

    // Full-width compares: addresses beyond the array never alias back into it.
    assign ld_oob      = (ld_addr >= LIMIT);
    assign ld_wr       = run && ld_en && !ld_oob;
    assign fetch_fault = (fetch_pc >= LIMIT) ||
                         ((FAULT_ON_MISALIGN != 0) && (fetch_pc[1:0] != 2'b00));

    assign fetch_ready = run && !ld_en && (!vld_p1 || instr_ready);
    assign accept      = fetch_valid && fetch_ready;

    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = fetch_pc[AW+1:2];
        ram_wdata = ld_data;
        if (!run) begin
            ram_we    = 1'b1;
            ram_addr  = cnt;
            ram_wdata = IMEM_NOP;
        end else if (ld_wr) begin
            ram_we    = 1'b1;
            ram_addr  = ld_addr[AW+1:2];
        end
    end

    imem_word_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_ram (
        .clk      (clk),
        .we       (ram_we),
        .re       (accept),
        .addr     (ram_addr),
        .wdata    (ram_wdata),
        .rdata_p1 (rdata_p1)
    );

    // p0 -> p1: response register, one entry deep
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p1   <= 1'b0;
            fault_p1 <= 1'b0;
            err_p1   <= 1'b0;
        end else begin
            if (accept) begin
                vld_p1   <= 1'b1;
                fault_p1 <= fetch_fault;
            end else if (instr_ready) begin
                vld_p1   <= 1'b0;
                fault_p1 <= 1'b0;
            end
            err_p1 <= run && ld_en && ld_oob;
        end
    end

    assign instr_valid = vld_p1;
    assign instr_fault = fault_p1;
    assign instr_code  = (vld_p1 && !fault_p1) ? rdata_p1 : IMEM_NOP;
    assign ld_err      = err_p1;

endmodule

// File: tb/tb_imem_fetch_port.sv
// Directed bench for imem_fetch_port: clear timing, load/fetch, stall, faults,
// load priority and reset abort, checked with immediate assertions.
module tb_imem_fetch_port;

    logic        clk;
    logic        reset;
    logic        init_done;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] fetch_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_code;
    logic        instr_fault;
    logic        ld_en;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;
    logic        ld_err;

    int   n_checks = 0;
    int   n_fail   = 0;
    logic bad;

    imem_fetch_port #(
        .ADDR_W            (32),
        .DEPTH_BYTES       (128),
        .FAULT_ON_MISALIGN (1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .init_done   (init_done),
        .fetch_valid (fetch_valid),
        .fetch_ready (fetch_ready),
        .fetch_pc    (fetch_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_code  (instr_code),
        .instr_fault (instr_fault),
        .ld_en       (ld_en),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .ld_err      (ld_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] d);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        step();
        ld_en = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_init_done"}, {31'b0, init_done}, 32'd0);
        chk({tag, "_valid"},     {31'b0, instr_valid}, 32'd0);
        chk({tag, "_fault"},     {31'b0, instr_fault}, 32'd0);
        chk({tag, "_code"},      instr_code, 32'd0);
        chk({tag, "_ld_err"},    {31'b0, ld_err}, 32'd0);
        chk({tag, "_ready"},     {31'b0, fetch_ready}, 32'd0);
    endtask

    // Counts 32 edges after release; init_done must stay low for 31 and rise on the 32nd.
    task automatic run_clear(input logic [31:0] ld_probe_addr);
        bad = 1'b0;
        for (int i = 1; i <= 32; i++) begin
            step();
            if (i < 32) bad = bad | init_done | fetch_ready | ld_err;
            if (i == 16) begin
                ld_en   = 1'b1;
                ld_addr = ld_probe_addr;
                ld_data = 32'h5555_5555;
            end
            if (i == 31) begin
                fetch_valid = 1'b0;
                ld_en       = 1'b0;
            end
        end
        chk("clear_quiet", {31'b0, bad}, 32'd0);
        chk("init_done_at_32", {31'b0, init_done}, 32'd1);
    endtask

    initial begin
        reset       = 1'b0;
        fetch_valid = 1'b0;
        fetch_pc    = 32'd0;
        instr_ready = 1'b1;
        ld_en       = 1'b0;
        ld_addr     = 32'd0;
        ld_data     = 32'd0;

        step();
        step();
        check_reset_outputs("rst0");

        // Test 1: clear sequence timing with fetch and out-of-range load held during it
        fetch_valid = 1'b1;
        reset       = 1'b1;
        run_clear(32'd200);
        #1 chk("ready_after_init", {31'b0, fetch_ready}, 32'd1);

        // Test 2: load then fetch
        @(negedge clk);
        ld_en   = 1'b1;
        ld_addr = 32'd0;
        ld_data = 32'h0800_0002;
        #1 chk("ld_blocks_ready", {31'b0, fetch_ready}, 32'd0);
        step();
        ld_en       = 1'b0;
        fetch_valid = 1'b1;
        fetch_pc    = 32'd0;
        #1 chk("ready_idle", {31'b0, fetch_ready}, 32'd1);
        step();
        chk("t2_valid", {31'b0, instr_valid}, 32'd1);
        chk("t2_code",  instr_code, 32'h0800_0002);
        chk("t2_fault", {31'b0, instr_fault}, 32'd0);
        fetch_valid = 1'b0;

        // Test 3: stall then back-to-back
        load(32'd8,  32'hCAFE_0008);
        load(32'd13, 32'h1234_5678);
        load(32'd16, 32'h0000_0010);
        chk("ld_err_inrange", {31'b0, ld_err}, 32'd0);
        fetch_valid = 1'b1;
        fetch_pc    = 32'd8;
        instr_ready = 1'b0;
        step();
        chk("t3_first", instr_code, 32'hCAFE_0008);
        fetch_pc = 32'd12;
        for (int j = 0; j < 3; j++) begin
            #1 chk("t3_hold_ready", {31'b0, fetch_ready}, 32'd0);
            step();
            chk("t3_hold_valid", {31'b0, instr_valid}, 32'd1);
            chk("t3_hold_code", instr_code, 32'hCAFE_0008);
        end
        instr_ready = 1'b1;
        #1 chk("t3_drain_ready", {31'b0, fetch_ready}, 32'd1);
        step();
        chk("t3_b2b_0", instr_code, 32'h1234_5678);
        fetch_pc = 32'd16;
        step();
        chk("t3_b2b_1", instr_code, 32'h0000_0010);
        chk("t3_b2b_valid", {31'b0, instr_valid}, 32'd1);
        fetch_valid = 1'b0;
        step();
        chk("t3_drained", {31'b0, instr_valid}, 32'd0);

        // Test 4: faults and out-of-range load
        fetch_valid = 1'b1;
        fetch_pc    = 32'd2;
        step();
        chk("t4_mis_fault", {31'b0, instr_fault}, 32'd1);
        chk("t4_mis_code",  instr_code, 32'd0);
        chk("t4_mis_valid", {31'b0, instr_valid}, 32'd1);
        fetch_pc = 32'd128;
        step();
        chk("t4_oob_fault", {31'b0, instr_fault}, 32'd1);
        chk("t4_oob_code",  instr_code, 32'd0);
        fetch_pc = 32'h8000_0000;
        step();
        chk("t4_wrap_fault", {31'b0, instr_fault}, 32'd1);
        fetch_pc = 32'd4;
        step();
        chk("t4_ok_fault", {31'b0, instr_fault}, 32'd0);
        chk("t4_ok_code",  instr_code, 32'd0);
        fetch_valid = 1'b0;
        load(32'd128, 32'hFFFF_FFFF);
        chk("t4_ld_err_pulse", {31'b0, ld_err}, 32'd1);
        step();
        chk("t4_ld_err_clear", {31'b0, ld_err}, 32'd0);
        fetch_valid = 1'b1;
        fetch_pc    = 32'd0;
        step();
        chk("t4_mem_unchanged", instr_code, 32'h0800_0002);
        fetch_valid = 1'b0;
        step();

        // Test 5: load and fetch to the same word in one cycle
        ld_en       = 1'b1;
        ld_addr     = 32'd12;
        ld_data     = 32'hDEAD_BEEF;
        fetch_valid = 1'b1;
        fetch_pc    = 32'd12;
        #1 chk("t5_ready_low", {31'b0, fetch_ready}, 32'd0);
        step();
        chk("t5_no_accept", {31'b0, instr_valid}, 32'd0);
        ld_en = 1'b0;
        step();
        chk("t5_new_word", instr_code, 32'hDEAD_BEEF);
        fetch_valid = 1'b0;
        step();

        // Test 6: reset mid-response, then mid-clear
        fetch_valid = 1'b1;
        fetch_pc    = 32'd0;
        instr_ready = 1'b0;
        step();
        chk("t6_pending", instr_code, 32'h0800_0002);
        fetch_valid = 1'b0;
        reset       = 1'b0;
        #1 check_reset_outputs("rst_resp");
        @(negedge clk);
        reset       = 1'b1;
        instr_ready = 1'b1;
        for (int i = 1; i <= 10; i++) step();
        reset = 1'b0;
        #1 check_reset_outputs("rst_clear");
        @(negedge clk);
        reset = 1'b1;
        run_clear(32'd0);
        fetch_valid = 1'b1;
        fetch_pc    = 32'd0;
        step();
        chk("t6_word0_zero", instr_code, 32'd0);
        chk("t6_word0_fault", {31'b0, instr_fault}, 32'd0);
        chk("t6_word0_valid", {31'b0, instr_valid}, 32'd1);
        fetch_pc = 32'd12;
        step();
        chk("t6_word3_zero", instr_code, 32'd0);
        fetch_valid = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
